sisc_core: RTL and testbench

SISC_CORE -- requirements
Module: sisc_core

---
 rtl/sisc_core.sv | 209 ++++++++++++++++++++
 tb/tb_sisc_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_core.sv
// sisc_core: small multi-cycle accumulator-free ALU core.
// Each instruction walks IDLE->DECODE->EXEC->WB; HALT parks the core.
module sisc_core #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [31:0]       ir,
    input  logic              ir_valid,
    output logic              ir_ready,
    output logic              done,
    output logic              illegal,
    output logic              halted,
    output logic [3:0]        stat,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_REG  = 4'd1;
    localparam logic [3:0] OP_IMM  = 4'd2;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [3:0]        flags_q, flags_d;
    logic              bad_q, bad_d;
    logic [3:0]        stat_q, stat_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];

    logic [3:0]        opc, mm, rd, rs, rt;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rf_view [16];
    logic              is_alu, bad_op, wr_ok;

    assign opc = ir_q[31:28];
    assign mm  = ir_q[27:24];
    assign rd  = ir_q[23:20];
    assign rs  = ir_q[19:16];
    assign rt  = ir_q[15:12];

    if (DATA_W > 16) begin : g_sext
        assign imm_ext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    end else begin : g_trunc
        assign imm_ext = ir_q[DATA_W-1:0];
    end

    assign is_alu = (opc == OP_REG) || (opc == OP_IMM);
    assign bad_op = (!is_alu && opc != OP_NOP) || (is_alu && mm[3]);
    assign wr_ok  = (rd != 4'd0) && (int'(rd) < NREG);

    // R0 and unimplemented addresses read as zero everywhere
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            rf_view[i] = (i == 0 || i >= NREG) ? '0 : regs_q[i];
        end
    end

    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v;
    logic [3:0]        alu_flags;
    logic [DATA_W:0]   sum, diff, shl_t, shr_t;
    logic [SH_W-1:0]   sh;

    always_comb begin
        sh      = b_q[SH_W-1:0];
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        shl_t   = {1'b0, a_q} << sh;
        shr_t   = {a_q, 1'b0} >> sh;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (mm)
            4'd0: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            4'd1: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = diff[DATA_W];
                alu_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            4'd2: alu_res = a_q & b_q;
            4'd3: alu_res = a_q | b_q;
            4'd4: alu_res = a_q ^ b_q;
            4'd5: alu_res = ~a_q;
            4'd6: begin
                alu_res = shl_t[DATA_W-1:0];
                alu_c   = shl_t[DATA_W];
            end
            4'd7: begin
                alu_res = shr_t[DATA_W:1];
                alu_c   = shr_t[0];
            end
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res == '0, alu_res[DATA_W-1], alu_c, alu_v};
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        flags_d   = flags_q;
        bad_d     = bad_q;
        stat_d    = stat_q;
        regs_d    = regs_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;
        halted_d  = halted_q;
        unique case (state_q)
            S_IDLE: begin
                if (ir_valid) begin
                    ir_d    = ir;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opc == OP_HALT) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                end else begin
                    a_d     = rf_view[rs];
                    b_d     = (opc == OP_IMM) ? imm_ext : rf_view[rt];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d     = alu_res;
                flags_d   = alu_flags;
                bad_d     = bad_op;
                illegal_d = illegal_q | bad_op;
                done_d    = 1'b1;
                state_d   = S_WB;
            end
            S_WB: begin
                // register write lands on the edge leaving WB
                if (is_alu && !bad_q) begin
                    stat_d = flags_q;
                    if (wr_ok) regs_d[rd] = res_q;
                end
                state_d = S_IDLE;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            bad_q     <= 1'b0;
            stat_q    <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            bad_q     <= bad_d;
            stat_q    <= stat_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            regs_q    <= regs_d;
        end
    end

    assign ir_ready = (state_q == S_IDLE) && !rst_f;
    assign done     = done_q;
    assign illegal  = illegal_q;
    assign halted   = halted_q;
    assign stat     = stat_q;
    assign dbg_data = rf_view[dbg_addr];

endmodule

// File: tb/tb_sisc_core.sv
// Directed bench for sisc_core: a 32-bit/16-reg and a 16-bit/8-reg core,
// exercised one at a time while the other is held in reset.
module tb_sisc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [31:0] ir;
    logic        ir_valid;
    logic [3:0]  dbg_addr;

    logic        rdy_a, done_a, ill_a, halt_a;
    logic [3:0]  stat_a;
    logic [31:0] dbd_a;
    logic        rdy_b, done_b, ill_b, halt_b;
    logic [3:0]  stat_b;
    logic [15:0] dbd_b;

    sisc_core #(.DATA_W(32), .NREG(16)) dut_a (
        .clk(clk), .rst_f(rst_a), .ir(ir), .ir_valid(ir_valid),
        .ir_ready(rdy_a), .done(done_a), .illegal(ill_a),
        .halted(halt_a), .stat(stat_a), .dbg_addr(dbg_addr),
        .dbg_data(dbd_a)
    );

    sisc_core #(.DATA_W(16), .NREG(8)) dut_b (
        .clk(clk), .rst_f(rst_b), .ir(ir), .ir_valid(ir_valid),
        .ir_ready(rdy_b), .done(done_b), .illegal(ill_b),
        .halted(halt_b), .stat(stat_b), .dbg_addr(dbg_addr),
        .dbg_data(dbd_b)
    );

    logic        sel;
    logic        o_rdy, o_done, o_ill, o_halt;
    logic [3:0]  o_stat;
    logic [31:0] o_dbg;

    assign o_rdy  = sel ? rdy_b  : rdy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_ill  = sel ? ill_b  : ill_a;
    assign o_halt = sel ? halt_b : halt_a;
    assign o_stat = sel ? stat_b : stat_a;
    assign o_dbg  = sel ? {16'd0, dbd_b} : dbd_a;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [16];

    typedef struct {
        string       tag;
        logic [3:0]  ad;
        logic [31:0] oldv;
        logic [31:0] newv;
        logic [3:0]  st;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst_b = v;
        else     rst_a = v;
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op,
        input logic [3:0] m, input logic [3:0] d, input logic [3:0] s,
        input logic [15:0] imm);
        return {op, m, d, s, imm};
    endfunction

    function automatic logic [31:0] enc1(input logic [3:0] m,
        input logic [3:0] d, input logic [3:0] s, input logic [3:0] t);
        return {4'd1, m, d, s, t, 12'h000};
    endfunction

    task automatic clear_mdl();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
    endtask

    task automatic do_reset();
        ir_valid = 1'b0;
        @(negedge clk);
        set_rst(1'b1);
        #1;
        chk("rst.ready", {31'd0, o_rdy}, 32'd0);
        chk("rst.done", {31'd0, o_done}, 32'd0);
        chk("rst.illegal", {31'd0, o_ill}, 32'd0);
        chk("rst.halted", {31'd0, o_halt}, 32'd0);
        chk("rst.stat", {28'd0, o_stat}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        set_rst(1'b0);
        #1;
        chk("rst.ready_rel", {31'd0, o_rdy}, 32'd1);
        clear_mdl();
    endtask

    // Expected outcome queued at issue, retired when done is seen
    task automatic issue(input logic [31:0] instr, input string tag,
                         input logic [31:0] newv, input logic [3:0] st);
        exp_t e;
        int   n;
        int   lat;
        e.tag  = tag;
        e.ad   = instr[23:20];
        e.oldv = mdl[e.ad];
        e.newv = newv;
        e.st   = st;
        sb.push_back(e);
        n = 0;
        while (o_rdy !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        ir       = instr;
        ir_valid = 1'b1;
        dbg_addr = instr[23:20];
        tick();
        ir  = 32'h23FF_0BAD;
        lat = 1;
        while (o_done !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        ir_valid = 1'b0;
        e = sb.pop_front();
        chk({e.tag, ".lat"}, lat, 32'd3);
        chk({e.tag, ".old"}, o_dbg, e.oldv);
        tick();
        chk({e.tag, ".reg"}, o_dbg, e.newv);
        chk({e.tag, ".stat"}, {28'd0, o_stat}, {28'd0, e.st});
        chk({e.tag, ".pulse"}, {31'd0, o_done}, 32'd0);
        mdl[e.ad] = e.newv;
    endtask

    task automatic run_suite(input logic s);
        logic [31:0] hb;
        logic [31:0] mx;
        logic [31:0] ones;
        int          dseen;
        int          rseen;
        sel  = s;
        hb   = s ? 32'h0000_8000 : 32'h8000_0000;
        mx   = s ? 32'h0000_7FFF : 32'h7FFF_FFFF;
        ones = s ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        do_reset();

        issue(enc(4'd2, 4'd0, 4'd1, 4'd0, 16'h0005), "add_i5", 32'd5, 4'b0000);
        issue(enc(4'd2, 4'd0, 4'd2, 4'd1, 16'hFFFF), "add_m1", 32'd4, 4'b0010);
        issue(enc(4'd2, 4'd0, 4'd1, 4'd0, 16'hFFFF), "ld_ones", ones, 4'b0100);
        issue(enc(4'd2, 4'd7, 4'd1, 4'd1, 16'h0001), "shr1", mx, 4'b0010);
        issue(enc(4'd2, 4'd0, 4'd3, 4'd1, 16'h0001), "add_ovf", hb, 4'b0101);
        issue(enc1(4'd1, 4'd5, 4'd3, 4'd3), "sub_self", 32'd0, 4'b1000);
        issue(enc(4'd2, 4'd0, 4'd6, 4'd0, 16'd33), "ld33", 32'd33, 4'b0000);
        issue(enc1(4'd6, 4'd7, 4'd3, 4'd6), "shl33", 32'd0, 4'b1010);
        issue(enc1(4'd6, 4'd4, 4'd1, 4'd0), "shl0", mx, 4'b0000);
        issue(enc(4'd2, 4'd2, 4'd5, 4'd1, 16'h00F0), "and", 32'hF0, 4'b0000);
        issue(enc(4'd2, 4'd3, 4'd5, 4'd0, 16'h1234), "or", 32'h1234, 4'b0000);
        issue(enc(4'd2, 4'd4, 4'd5, 4'd1, 16'hFFFF), "xor", hb, 4'b0100);
        issue(enc(4'd2, 4'd5, 4'd5, 4'd0, 16'h0000), "not", ones, 4'b0100);
        issue(enc1(4'd1, 4'd5, 4'd6, 4'd1), "sub_brw", hb + 32'd34, 4'b0110);
        issue(enc(4'd2, 4'd6, 4'd5, 4'd1, 16'h0004), "shl4", ones ^ 32'hF,
              4'b0110);
        issue(enc1(4'd1, 4'd5, 4'd3, 4'd6), "sub_ovf", mx - 32'd32, 4'b0001);
        issue(enc(4'd2, 4'd0, 4'd0, 4'd1, 16'h0001), "rd0", 32'd0, 4'b0101);
        issue(enc(4'd2, 4'd0, 4'd9, 4'd0, 16'h0007), "rd9",
              s ? 32'd0 : 32'd7, 4'b0000);
        issue(enc(4'd0, 4'd0, 4'd1, 4'd0, 16'h0005), "nop", mx, 4'b0000);
        chk("nop.illegal", {31'd0, o_ill}, 32'd0);
        issue(enc(4'd7, 4'd0, 4'd1, 4'd0, 16'h0005), "op7", mx, 4'b0000);
        chk("op7.illegal", {31'd0, o_ill}, 32'd1);
        issue(enc(4'd2, 4'd9, 4'd2, 4'd0, 16'h0005), "mm9", 32'd4, 4'b0000);
        chk("mm9.illegal", {31'd0, o_ill}, 32'd1);

        // reset lands while the write to R4 is in EXEC
        dbg_addr = 4'd4;
        ir       = enc(4'd2, 4'd0, 4'd4, 4'd0, 16'h0055);
        ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick();
        set_rst(1'b1);
        #1;
        chk("abort.done", {31'd0, o_done}, 32'd0);
        chk("abort.ready", {31'd0, o_rdy}, 32'd0);
        tick();
        chk("abort.r4_rst", o_dbg, 32'd0);
        @(negedge clk);
        set_rst(1'b0);
        dseen = 0;
        repeat (4) begin
            tick();
            if (o_done) dseen++;
        end
        chk("abort.no_done", dseen, 32'd0);
        chk("abort.r4", o_dbg, 32'd0);
        chk("abort.illegal", {31'd0, o_ill}, 32'd0);
        chk("abort.stat", {28'd0, o_stat}, 32'd0);
        clear_mdl();

        // HALT with a valid request held against it
        ir       = enc(4'd15, 4'd0, 4'd0, 4'd0, 16'h0000);
        ir_valid = 1'b1;
        tick();
        ir       = enc(4'd2, 4'd0, 4'd1, 4'd0, 16'h0005);
        dbg_addr = 4'd1;
        dseen    = 0;
        rseen    = 0;
        repeat (20) begin
            tick();
            if (o_done) dseen++;
            if (o_rdy) rseen++;
        end
        chk("halt.halted", {31'd0, o_halt}, 32'd1);
        chk("halt.ready", {31'd0, o_rdy}, 32'd0);
        chk("halt.no_done", dseen, 32'd0);
        chk("halt.no_ready", rseen, 32'd0);
        chk("halt.r1", o_dbg, 32'd0);
        ir_valid = 1'b0;
        @(negedge clk);
        set_rst(1'b1);
        #1;
        chk("halt.rst_clr", {31'd0, o_halt}, 32'd0);
        @(negedge clk);
        set_rst(1'b0);
        #1;
        chk("halt.ready_rel", {31'd0, o_rdy}, 32'd1);
        issue(enc(4'd2, 4'd0, 4'd1, 4'd0, 16'h0005), "post_halt", 32'd5,
              4'b0000);

        set_rst(1'b1);
        #1;
    endtask

    initial begin
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        ir       = '0;
        ir_valid = 1'b0;
        dbg_addr = '0;
        sel      = 1'b0;
        clear_mdl();
        repeat (2) @(posedge clk);
        run_suite(1'b0);
        run_suite(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

endmodule
